// File: rtl/div_sequencer_if.sv
// Operand request and result response handshakes between the div_sequencer and its upstream/downstream logic.
interface div_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quotient;
  logic [WIDTH-1:0] out_remainder;
  logic             out_div_zero;
  logic             out_timeout;

  modport master (
    output in_valid, in_dividend, in_divisor, out_ready,
    input  in_ready, out_valid, out_quotient, out_remainder, out_div_zero, out_timeout
  );

  modport slave (
    input  in_valid, in_dividend, in_divisor, out_ready,
    output in_ready, out_valid, out_quotient, out_remainder, out_div_zero, out_timeout
  );
endinterface

// File: rtl/div_sequencer.sv
// Sequencer in front of a restarting restore-division core: it accepts operands, restarts the core, and returns the result.
// Divide-by-zero is answered locally, and a watchdog aborts a core that never reports ready.
module div_sequencer #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 4 * WIDTH + 8
) (
  input  logic                 clock,
  input  logic                 reset,
  div_sequencer_if.slave       bus,
  output logic                 div_reset_n,
  output logic [WIDTH-1:0]     div_i0,
  output logic [WIDTH-1:0]     div_i1,
  input  logic [WIDTH-1:0]     div_o0,
  input  logic [WIDTH-1:0]     div_o1,
  input  logic                 div_ready
);

  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            state;
  logic [WD_W-1:0]   wd;
  logic              in_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  out_quotient;
  logic [WIDTH-1:0]  out_remainder;
  logic              out_div_zero;
  logic              out_timeout;

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid;
  assign bus.out_quotient  = out_quotient;
  assign bus.out_remainder = out_remainder;
  assign bus.out_div_zero  = out_div_zero;
  assign bus.out_timeout   = out_timeout;

  // Every output is registered and is set together with the state it belongs to, so none of them can glitch.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      wd            <= '0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_div_zero  <= 1'b0;
      out_timeout   <= 1'b0;
      div_reset_n   <= 1'b0;
      div_i0        <= '0;
      div_i1        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready <= 1'b0;
            if (bus.in_divisor != '0) begin
              div_i0 <= bus.in_dividend;
              div_i1 <= bus.in_divisor;
              state  <= LOAD;
            end else begin
              out_quotient  <= '1;
              out_remainder <= bus.in_dividend;
              out_div_zero  <= 1'b1;
              out_timeout   <= 1'b0;
              out_valid     <= 1'b1;
              state         <= RESP;
            end
          end
        end
        // The core stays in reset for one cycle with stable operands, so a stale ready from it cannot be seen.
        LOAD: begin
          wd          <= '0;
          div_reset_n <= 1'b1;
          state       <= RUN;
        end
        RUN: begin
          wd <= wd + WD_W'(1);
          if (div_ready) begin
            out_quotient  <= div_o0;
            out_remainder <= div_o1;
            out_div_zero  <= 1'b0;
            out_timeout   <= 1'b0;
            out_valid     <= 1'b1;
            div_reset_n   <= 1'b0;
            state         <= RESP;
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            out_quotient  <= '0;
            out_remainder <= '0;
            out_div_zero  <= 1'b0;
            out_timeout   <= 1'b1;
            out_valid     <= 1'b1;
            div_reset_n   <= 1'b0;
            state         <= RESP;
          end
        end
        RESP: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed testbench for div_sequencer with a behavioural restarting divider core model.
module tb_div_sequencer;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned CORE_LAT = 4 * WIDTH + 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             div_reset_n;
  logic [WIDTH-1:0] div_i0, div_i1, div_o0, div_o1;
  logic             div_ready;
  logic             core_dead = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ccnt = 0;
  int rn_first, rn_last, rn_count;
  int t_acc, t_out;

  div_sequencer_if #(.WIDTH(WIDTH)) bus ();

  div_sequencer #(.WIDTH(WIDTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus.slave),
    .div_reset_n (div_reset_n),
    .div_i0      (div_i0),
    .div_i1      (div_i1),
    .div_o0      (div_o0),
    .div_o1      (div_o1),
    .div_ready   (div_ready)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Core model: restarts while div_reset_n is low and reports ready 4*WIDTH+2 cycles after release.
  always @(posedge clock) begin
    if (!div_reset_n) ccnt <= 0;
    else              ccnt <= ccnt + 1;
  end
  assign div_ready = !core_dead && div_reset_n && (ccnt >= CORE_LAT);
  assign div_o0    = (div_i1 != 0) ? div_i0 / div_i1 : '0;
  assign div_o1    = (div_i1 != 0) ? div_i0 % div_i1 : '0;

  always @(negedge clock) begin
    if (div_reset_n === 1'b1) begin
      if (rn_first < 0) rn_first = cyc;
      rn_last  = cyc;
      rn_count = rn_count + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bit done = 1'b0;
    @(posedge clock);
    #1;
    bus.in_valid    = 1'b1;
    bus.in_dividend = a;
    bus.in_divisor  = b;
    rn_first = -1;
    rn_last  = -1;
    rn_count = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      if (bus.in_ready) begin
        t_acc = cyc;
        done  = 1'b1;
      end
    end
    check_eq("accept", 32'(done), 32'd1);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      if (bus.out_valid) begin
        t_out = cyc;
        done  = 1'b1;
      end
    end
    check_eq("out_valid_seen", 32'(done), 32'd1);
  endtask

  // Completes the result handshake from a negedge and checks the sequencer is ready again next cycle.
  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clock);
    check_eq("in_ready_after_take", 32'(bus.in_ready), 32'd1);
    check_eq("out_valid_after_take", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r,
                              input logic dz, input logic to);
    check_eq({tag, "_q"},  32'(bus.out_quotient), 32'(q));
    check_eq({tag, "_r"},  32'(bus.out_remainder), 32'(r));
    check_eq({tag, "_dz"}, 32'(bus.out_div_zero), 32'(dz));
    check_eq({tag, "_to"}, 32'(bus.out_timeout), 32'(to));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rn_first = -1;
    rn_last  = -1;
    rn_count = 0;
    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_dividend = '0;
    bus.in_divisor  = '0;
    bus.out_ready   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_result("rst", 16'h0, 16'h0, 1'b0, 1'b0);
    check_eq("rst_div_reset_n", 32'(div_reset_n), 32'd0);
    check_eq("rst_div_i0", 32'(div_i0), 32'd0);
    check_eq("rst_div_i1", 32'(div_i1), 32'd0);

    // 100 / 7 with full latency and core-release window
    send(16'd100, 16'd7);
    wait_out();
    check_eq("lat_100_7", 32'(t_out - t_acc), 32'd68);
    check_result("d100_7", 16'd14, 16'd2, 1'b0, 1'b0);
    check_eq("rn_first", 32'(rn_first - t_acc), 32'd2);
    check_eq("rn_last", 32'(rn_last - t_acc), 32'd67);
    check_eq("rn_count", 32'(rn_count), 32'd66);
    take();

    // back-to-back operand extremes
    send(16'hFFFF, 16'h0001);
    wait_out();
    check_result("dffff_1", 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    take();
    send(16'h1234, 16'hFFFF);
    wait_out();
    check_eq("lat_1234", 32'(t_out - t_acc), 32'd68);
    check_result("d1234_ffff", 16'h0000, 16'h1234, 1'b0, 1'b0);
    take();

    // divide by zero bypass
    send(16'd5, 16'd0);
    wait_out();
    check_eq("lat_dz", 32'(t_out - t_acc), 32'd1);
    check_result("d5_0", 16'hFFFF, 16'd5, 1'b1, 1'b0);
    take();
    check_eq("dz_rn_count", 32'(rn_count), 32'd0);

    // backpressure with a competing request held on the input
    send(16'd200, 16'd9);
    wait_out();
    bus.in_valid    = 1'b1;
    bus.in_dividend = 16'd1;
    bus.in_divisor  = 16'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check_eq("bp_valid", 32'(bus.out_valid), 32'd1);
      check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("bp_q", 32'(bus.out_quotient), 32'd22);
      check_eq("bp_r", 32'(bus.out_remainder), 32'd2);
    end
    take();
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    wait_out();
    check_result("d1_1", 16'd1, 16'd0, 1'b0, 1'b0);
    take();

    // synchronous reset in the middle of RUN
    send(16'd1000, 16'd3);
    while (cyc < t_acc + 30) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check_eq("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("mid_rst_div_reset_n", 32'(div_reset_n), 32'd0);
    send(16'd9, 16'd3);
    wait_out();
    check_result("d9_3", 16'd3, 16'd0, 1'b0, 1'b0);
    take();

    // watchdog abort with a core that never reports ready
    core_dead = 1'b1;
    send(16'd50, 16'd5);
    wait_out();
    check_eq("lat_timeout", 32'(t_out - t_acc), 32'd74);
    check_result("d50_5_to", 16'd0, 16'd0, 1'b0, 1'b1);
    take();
    core_dead = 1'b0;
    check_eq("to_rn_after", 32'(div_reset_n), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Front-end sequencer that sits directly upstream of the WIDTH-bit restarting restore-division core. It accepts operand pairs over a valid/ready handshake and registers them. It restarts the core by holding the core's active-low reset, waits for the core's ready, then returns quotient/remainder over a second valid/ready handshake. Divide-by-zero is handled locally without running the core, and a watchdog catches a core that never signals ready.

## Interface
- WIDTH, 16, operand/result width; must match the divider core.
- TIMEOUT, 4*WIDTH+8, maximum RUN cycles before abort; must be ≥ 4*WIDTH+2.

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  sequencer can accept operands
- in_dividend  in  WIDTH  dividend
- in_divisor  in  WIDTH  divisor
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_quotient  out  WIDTH  quotient
- out_remainder  out  WIDTH  remainder
- out_div_zero  out  1  result is divide-by-zero bypass
- out_timeout  out  1  result is watchdog abort
- div_reset_n  out  1  drives the core's active-low reset
- div_i0  out  WIDTH  core dividend, registered
- div_i1  out  WIDTH  core divisor, registered
- div_o0  in  WIDTH  core quotient
- div_o1  in  WIDTH  core remainder
- div_ready  in  1  core done flag

## Operation
- States: IDLE, LOAD, RUN, RESP.
- Reset: state IDLE. in_ready=1. out_valid=0. out_quotient, out_remainder, out_div_zero, out_timeout, div_i0, div_i1 all 0. div_reset_n=0. Watchdog counter 0.
- div_reset_n = 1 only in RUN. It is registered, so it is decoded from next state and does not glitch.
- IDLE: in_ready=1.
  - On in_valid with divisor ≠ 0: register operands into div_i0/div_i1, go to LOAD.
  - On in_valid with divisor = 0: load out_quotient={WIDTH{1}}, out_remainder=dividend, out_div_zero=1, out_timeout=0; go to RESP. The core is not started.
- LOAD: one cycle with the core held in reset and operands stable. Clear the watchdog. Go to RUN.
- RUN: increment the watchdog each cycle.
  - On div_ready=1: capture div_o0/div_o1 into out_quotient/out_remainder, clear both flags, go to RESP.
  - Otherwise, when the watchdog reaches TIMEOUT-1: load out_quotient=0, out_remainder=0, out_timeout=1, go to RESP.
  - If div_ready and the timeout occur in the same cycle, div_ready wins.
- RESP: out_valid=1. Outputs are held stable until out_valid&out_ready, then go to IDLE.
- in_ready is 0 in LOAD, RUN and RESP. in_valid is ignored there and no operands are dropped silently; the upstream must hold them.
- div_ready is ignored outside RUN. It is stale-safe because the core is held in reset during LOAD.
- Synchronous reset in any state (including mid-RUN) forces the reset values on the next edge. Any in-flight result is discarded, and the core is re-held in reset.

## Timing
- Accept at cycle T (in_valid&in_ready). LOAD at T+1. RUN starts at T+2. The core's ready appears at T+4*WIDTH+3 and out_valid at T+4*WIDTH+4 (T+68 for WIDTH=16).
- Divide-by-zero: out_valid at T+1.
- Timeout: out_valid at T+TIMEOUT+2 (T+74 by default).
- Result handshake at cycle R: in_ready=1 at R+1. Maximum throughput is one operation per 4*WIDTH+5 cycles.
- out_valid never drops without out_ready, except on reset.

## Test plan
- 100/7 accepted at T → out_valid at T+68; q=14, r=2; both flags 0. div_reset_n is high exactly on cycles T+2..T+67.
- 0xFFFF/1 → q=0xFFFF, r=0. Then 0x1234/0xFFFF → q=0, r=0x1234. Operations are back to back; in_ready rises the cycle after the first result handshake.
- 5/0 → out_valid at T+1 with q=0xFFFF, r=5, out_div_zero=1. div_reset_n stays 0 throughout.
- Backpressure: run 200/9 and hold out_ready=0 for 10 cycles after out_valid → q=22, r=2, held stable. in_ready=0 and a competing in_valid is ignored. After out_ready, the next operand is accepted.
- Reset asserted at T+30 during RUN → next cycle: out_valid=0, in_ready=1, div_reset_n=0. A following 9/3 → q=3, r=0.
- Core model with div_ready tied 0, operation 50/5 → out_valid at T+74 with out_timeout=1, q=0, r=0. The sequencer then returns to IDLE.
